// File: rtl/axis_broadcast_mask.sv
// AXI-Stream 1:M frame broadcaster; destination mask is latched on the first beat and held to tlast.
// Each output owns an output register plus one skid slot, so a stalled port costs one beat of slack.
module axis_broadcast_mask #(
  parameter int M_COUNT     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
  parameter int LAST_ENABLE = 1,
  parameter int ID_ENABLE   = 0,
  parameter int ID_WIDTH    = 8,
  parameter int DEST_ENABLE = 0,
  parameter int DEST_WIDTH  = 8,
  parameter int USER_ENABLE = 1,
  parameter int USER_WIDTH  = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_WIDTH-1:0]            s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]            s_axis_tkeep,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic                             s_axis_tlast,
  input  logic [ID_WIDTH-1:0]              s_axis_tid,
  input  logic [DEST_WIDTH-1:0]            s_axis_tdest,
  input  logic [USER_WIDTH-1:0]            s_axis_tuser,
  input  logic [M_COUNT-1:0]               s_axis_tmask,
  output logic [M_COUNT*DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [M_COUNT*KEEP_WIDTH-1:0]    m_axis_tkeep,
  output logic [M_COUNT-1:0]               m_axis_tvalid,
  input  logic [M_COUNT-1:0]               m_axis_tready,
  output logic [M_COUNT-1:0]               m_axis_tlast,
  output logic [M_COUNT*ID_WIDTH-1:0]      m_axis_tid,
  output logic [M_COUNT*DEST_WIDTH-1:0]    m_axis_tdest,
  output logic [M_COUNT*USER_WIDTH-1:0]    m_axis_tuser,
  output logic                             drop_frame
);

  localparam int BW = DATA_WIDTH + KEEP_WIDTH + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;

  // state    | meaning
  // ST_IDLE  | between frames; mask comes straight from s_axis_tmask
  // ST_FRAME | inside a frame; mask held in r_mask until tlast
  typedef enum logic {ST_IDLE, ST_FRAME} state_t;

  state_t               r_state;
  logic [M_COUNT-1:0]   r_mask;
  logic                 r_drop;
  logic [M_COUNT-1:0]   r_out_valid;
  logic [M_COUNT-1:0]   r_tmp_valid;
  logic [BW-1:0]        r_out_beat [M_COUNT];
  logic [BW-1:0]        r_tmp_beat [M_COUNT];

  logic [KEEP_WIDTH-1:0] w_in_keep;
  logic                  w_in_last;
  logic [ID_WIDTH-1:0]   w_in_id;
  logic [DEST_WIDTH-1:0] w_in_dest;
  logic [USER_WIDTH-1:0] w_in_user;
  logic [BW-1:0]         w_in_beat;
  logic [M_COUNT-1:0]    w_eff_mask;
  logic [M_COUNT-1:0]    w_sel;
  logic [M_COUNT-1:0]    w_out_free;
  logic                  w_accept;

  assign w_in_keep = (KEEP_ENABLE != 0) ? s_axis_tkeep : '1;
  assign w_in_last = (LAST_ENABLE != 0) ? s_axis_tlast : 1'b1;
  assign w_in_id   = (ID_ENABLE   != 0) ? s_axis_tid   : '0;
  assign w_in_dest = (DEST_ENABLE != 0) ? s_axis_tdest : '0;
  assign w_in_user = (USER_ENABLE != 0) ? s_axis_tuser : '0;
  assign w_in_beat = {s_axis_tdata, w_in_keep, w_in_last, w_in_id, w_in_dest, w_in_user};

  // Ready depends only on skid occupancy, never on m_axis_tready.
  assign s_axis_tready = ~rst & ~(|r_tmp_valid);
  assign w_accept      = s_axis_tvalid & s_axis_tready;
  assign w_eff_mask    = (r_state == ST_FRAME) ? r_mask : s_axis_tmask;
  assign w_sel         = {M_COUNT{w_accept}} & w_eff_mask;
  assign w_out_free    = ~r_out_valid | m_axis_tready;
  assign drop_frame    = r_drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_mask  <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_drop <= w_accept & w_in_last & (w_eff_mask == '0);
      if (w_accept) begin
        if (w_in_last) begin
          r_state <= ST_IDLE;
        end else if (r_state == ST_IDLE) begin
          r_mask  <= s_axis_tmask;
          r_state <= ST_FRAME;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= '0;
      r_tmp_valid <= '0;
    end else begin
      for (int i = 0; i < M_COUNT; i++) begin
        if (w_out_free[i]) begin
          r_out_valid[i] <= r_tmp_valid[i] | w_sel[i];
          r_tmp_valid[i] <= 1'b0;
        end else if (w_sel[i]) begin
          r_tmp_valid[i] <= 1'b1;
        end
      end
    end
  end

  // Payload registers carry no reset; validity is tracked separately above.
  always_ff @(posedge clk) begin
    for (int i = 0; i < M_COUNT; i++) begin
      if (w_out_free[i]) begin
        if (r_tmp_valid[i]) begin
          r_out_beat[i] <= r_tmp_beat[i];
        end else if (w_sel[i]) begin
          r_out_beat[i] <= w_in_beat;
        end
      end else if (w_sel[i]) begin
        r_tmp_beat[i] <= w_in_beat;
      end
    end
  end

  assign m_axis_tvalid = r_out_valid;

  for (genvar i = 0; i < M_COUNT; i++) begin : g_out
    assign {m_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH],
            m_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH],
            m_axis_tlast[i],
            m_axis_tid[i*ID_WIDTH +: ID_WIDTH],
            m_axis_tdest[i*DEST_WIDTH +: DEST_WIDTH],
            m_axis_tuser[i*USER_WIDTH +: USER_WIDTH]} = r_out_beat[i];
  end

endmodule

// File: tb/tb_axis_broadcast_mask.sv
// Directed bench for axis_broadcast_mask: broadcast, masking, mask hold, skid stall, drop and reset.
module tb_axis_broadcast_mask;

  logic        clk;
  logic        rst;
  logic [7:0]  s_axis_tdata;
  logic [0:0]  s_axis_tkeep;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [7:0]  s_axis_tid;
  logic [7:0]  s_axis_tdest;
  logic [0:0]  s_axis_tuser;
  logic [3:0]  s_axis_tmask;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic [3:0]  m_axis_tvalid;
  logic [3:0]  m_axis_tready;
  logic [3:0]  m_axis_tlast;
  logic [31:0] m_axis_tid;
  logic [31:0] m_axis_tdest;
  logic [3:0]  m_axis_tuser;
  logic        drop_frame;

  axis_broadcast_mask dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tid(s_axis_tid),
    .s_axis_tdest(s_axis_tdest), .s_axis_tuser(s_axis_tuser), .s_axis_tmask(s_axis_tmask),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid),
    .m_axis_tdest(m_axis_tdest), .m_axis_tuser(m_axis_tuser), .drop_frame(drop_frame)
  );

  typedef struct {
    int         port;
    logic [7:0] data;
    logic       last;
    int         cyc;
  } beat_t;

  beat_t log_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc = 0;
  int    acc_cyc = 0;
  int    drop_cnt = 0;
  int    drop_cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  // Outputs and handshakes are recorded mid-cycle, after inputs have settled.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (m_axis_tvalid[i] && m_axis_tready[i])
          log_q.push_back('{i, m_axis_tdata[i*8 +: 8], m_axis_tlast[i], cyc});
      end
      if (drop_frame) begin
        drop_cnt++;
        drop_cyc = cyc;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic send_beat(input logic [7:0] data, input logic last, input logic [3:0] mask);
    int  t;
    logic ok;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = data;
    s_axis_tlast  = last;
    s_axis_tmask  = mask;
    t  = 0;
    ok = 1'b0;
    do begin
      @(negedge clk);
      ok      = s_axis_tready;
      acc_cyc = cyc;
      @(posedge clk);
      #1;
      t++;
    end while (!ok && t < 200);
    check_eq("send_accept", ok, 1'b1);
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // exp holds n beats, first beat in the most significant byte; tlast expected on the final one only.
  task automatic check_stream(input string tag, input int port, input logic [63:0] exp, input int n);
    int k;
    k = 0;
    foreach (log_q[j]) begin
      if (log_q[j].port == port) begin
        if (k < n) begin
          check_eq({tag, "_data"}, log_q[j].data, exp[(n-1-k)*8 +: 8]);
          check_eq({tag, "_last"}, log_q[j].last, (k == n-1));
        end
        k++;
      end
    end
    check_eq({tag, "_count"}, k, n);
  endtask

  int first_acc;
  int first_out_cyc;
  int last_out_cyc;

  initial begin
    rst = 1'b1;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    s_axis_tid = 8'h5A; s_axis_tdest = 8'hA5; s_axis_tuser = '0; s_axis_tmask = '0;
    m_axis_tready = 4'hF;
    #3;
    check_eq("rst_tready", s_axis_tready, 1'b0);
    check_eq("rst_tvalid", m_axis_tvalid, 4'h0);
    check_eq("rst_drop", drop_frame, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_tready", s_axis_tready, 1'b1);
    @(posedge clk); #1;

    // 1: full broadcast, latency and back-to-back timing
    log_q.delete();
    send_beat(8'hAA, 1'b0, 4'hF);
    first_acc = acc_cyc;
    send_beat(8'hBB, 1'b0, 4'hF);
    send_beat(8'hCC, 1'b1, 4'hF);
    idle(4);
    for (int p = 0; p < 4; p++) check_stream($sformatf("t1_p%0d", p), p, 64'hAABBCC, 3);
    first_out_cyc = -1;
    last_out_cyc  = -1;
    foreach (log_q[j]) begin
      if (log_q[j].port == 0) begin
        if (first_out_cyc < 0) first_out_cyc = log_q[j].cyc;
        last_out_cyc = log_q[j].cyc;
      end
    end
    check_eq("t1_latency", first_out_cyc - first_acc, 1);
    check_eq("t1_consecutive", last_out_cyc - first_out_cyc, 2);
    check_eq("t1_keep_ones", m_axis_tkeep, 4'hF);
    check_eq("t1_tid_zero", m_axis_tid, 32'h0);
    check_eq("t1_idle_tvalid", m_axis_tvalid, 4'h0);

    // 2: partial mask
    log_q.delete();
    send_beat(8'h21, 1'b0, 4'b0101);
    send_beat(8'h22, 1'b1, 4'b0101);
    idle(4);
    check_stream("t2_p0", 0, 64'h2122, 2);
    check_stream("t2_p1", 1, 64'h0, 0);
    check_stream("t2_p2", 2, 64'h2122, 2);
    check_stream("t2_p3", 3, 64'h0, 0);

    // 3: mask held mid-frame, new mask applies to the next frame
    log_q.delete();
    send_beat(8'h31, 1'b0, 4'b0001);
    send_beat(8'h32, 1'b0, 4'b1110);
    send_beat(8'h33, 1'b1, 4'b1110);
    send_beat(8'h41, 1'b0, 4'b1110);
    send_beat(8'h42, 1'b1, 4'b1110);
    idle(4);
    check_stream("t3_p0", 0, 64'h313233, 3);
    for (int p = 1; p < 4; p++) check_stream($sformatf("t3_p%0d", p), p, 64'h4142, 2);

    // 4: one stalled output fills its skid slot and back-pressures the source
    log_q.delete();
    m_axis_tready = 4'b1101;
    send_beat(8'h10, 1'b0, 4'hF);
    send_beat(8'h11, 1'b0, 4'hF);
    s_axis_tdata = 8'h12;
    @(negedge clk);
    check_eq("t4_ready_low", s_axis_tready, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("t4_ready_held", s_axis_tready, 1'b0);
    @(posedge clk); #1;
    m_axis_tready = 4'hF;
    send_beat(8'h12, 1'b0, 4'hF);
    send_beat(8'h13, 1'b0, 4'hF);
    send_beat(8'h14, 1'b0, 4'hF);
    send_beat(8'h15, 1'b0, 4'hF);
    send_beat(8'h16, 1'b0, 4'hF);
    send_beat(8'h17, 1'b1, 4'hF);
    idle(4);
    for (int p = 0; p < 4; p++) check_stream($sformatf("t4_p%0d", p), p, 64'h1011121314151617, 8);

    // 5: zero-mask frame is swallowed with a single drop pulse
    log_q.delete();
    drop_cnt = 0;
    send_beat(8'h51, 1'b0, 4'h0);
    first_acc = acc_cyc;
    send_beat(8'h52, 1'b0, 4'h0);
    send_beat(8'h53, 1'b0, 4'h0);
    send_beat(8'h54, 1'b1, 4'h0);
    check_eq("t5_rate", acc_cyc - first_acc, 3);
    idle(4);
    check_eq("t5_no_output", log_q.size(), 0);
    check_eq("t5_drop_count", drop_cnt, 1);
    check_eq("t5_drop_timing", drop_cyc - acc_cyc, 1);

    // 6: reset with every skid slot occupied, then a clean frame to port 1
    m_axis_tready = 4'h0;
    send_beat(8'h61, 1'b0, 4'hF);
    send_beat(8'h62, 1'b0, 4'hF);
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    check_eq("t6_full_ready", s_axis_tready, 1'b0);
    check_eq("t6_full_valid", m_axis_tvalid, 4'hF);
    #2 rst = 1'b1;
    #1;
    check_eq("t6_rst_valid", m_axis_tvalid, 4'h0);
    check_eq("t6_rst_ready", s_axis_tready, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    m_axis_tready = 4'hF;
    log_q.delete();
    send_beat(8'h71, 1'b0, 4'b0010);
    send_beat(8'h72, 1'b1, 4'b0010);
    idle(4);
    check_stream("t6_p0", 0, 64'h0, 0);
    check_stream("t6_p1", 1, 64'h7172, 2);
    check_stream("t6_p2", 2, 64'h0, 0);
    check_stream("t6_p3", 3, 64'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
